// File: rtl/hms_pkg.sv
// Shared constants and types for the HH:MM:SS counter that feeds the six-digit display driver.
package hms_pkg;

   localparam int unsigned DIGIT_W = 6;

   typedef logic [DIGIT_W-1:0] digit_t;

   // Digit code the display driver renders dark.
   localparam digit_t BLANK_CODE = 6'b111111;

   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MIN_MAX  = 59;
   localparam int unsigned HOUR_MAX = 23;

endpackage

// File: rtl/hms_time_counter_if.sv
// Control inputs and digit/strobe outputs of hms_time_counter, grouped as one bus.
interface hms_time_counter_if #(
   parameter int unsigned DIGIT_W = hms_pkg::DIGIT_W
);

   logic               en;
   logic               inc_min;
   logic               inc_hour;
   logic [DIGIT_W-1:0] D0;
   logic [DIGIT_W-1:0] D1;
   logic [DIGIT_W-1:0] D2;
   logic [DIGIT_W-1:0] D3;
   logic [DIGIT_W-1:0] D4;
   logic [DIGIT_W-1:0] D5;
   logic               sec_pulse;

   modport master (
      output en, inc_min, inc_hour,
      input  D0, D1, D2, D3, D4, D5, sec_pulse
   );

   modport slave (
      input  en, inc_min, inc_hour,
      output D0, D1, D2, D3, D4, D5, sec_pulse
   );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping after TensMax:OnesMax; tick increments chain through carry_in_en,
// set_inc increments unconditionally without producing a carry.
module bcd_mod_counter
   import hms_pkg::*;
#(
   parameter int unsigned TensMax       = 5,
   parameter int unsigned OnesMax       = 9,
   parameter int unsigned DIGIT_W       = hms_pkg::DIGIT_W,
   parameter bit          BlankZeroTens = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               set_inc,
   input  logic               carry_in_en,
   output logic [DIGIT_W-1:0] ones,
   output logic [DIGIT_W-1:0] tens,
   output logic               carry_out
);

   localparam logic [3:0] TensLim = 4'(TensMax);
   localparam logic [3:0] OnesLim = 4'(OnesMax);

   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;
   logic       at_max;
   logic       advance;

   always_comb begin
      at_max    = (tens_q == TensLim) && (ones_q == OnesLim);
      advance   = set_inc | (inc & carry_in_en);
      carry_out = ~set_inc & inc & carry_in_en & at_max;
      ones_d    = ones_q;
      tens_d    = tens_q;
      if (advance) begin
         if (at_max) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
         end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end

   assign ones = DIGIT_W'(ones_q);

   if (BlankZeroTens) begin : g_blank
      // Separate output flop so the blanked word stays registered while tens_q keeps the value.
      localparam logic [DIGIT_W-1:0] Blank = '1;
      logic [DIGIT_W-1:0] tens_word_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            tens_word_q <= Blank;
         end else begin
            tens_word_q <= (tens_d == 4'd0) ? Blank : DIGIT_W'(tens_d);
         end
      end

      assign tens = tens_word_q;
   end else begin : g_plain
      assign tens = DIGIT_W'(tens_q);
   end

endmodule

// File: rtl/hms_time_counter.sv
// 24-hour HH:MM:SS time keeper with 1 Hz prescaler, run/pause and manual minute/hour set.
// Build option: define HMS_LEADING_BLANK_EN to blank D5 while the hours tens digit is zero.
module hms_time_counter
   import hms_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned DIGIT_W  = hms_pkg::DIGIT_W
) (
   input logic               clk,
   input logic               rst,
   hms_time_counter_if.slave bus
);

   localparam int unsigned     CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

`ifdef HMS_LEADING_BLANK_EN
   localparam bit BlankLead = 1'b1;
`else
   localparam bit BlankLead = 1'b0;
`endif

   logic [CntW-1:0] presc_q, presc_d;
   logic            tick;
   logic            tick_apply;
   logic            sec_pulse_q;
   logic            sec_carry;
   logic            min_carry;
   logic            unused_hour_carry;

   always_comb begin
      tick    = bus.en && (presc_q == CntLast);
      presc_d = presc_q;
      if (bus.en) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      // A manual set swallows a coincident tick; the prescaler still wraps.
      tick_apply = tick & ~(bus.inc_min | bus.inc_hour);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         sec_pulse_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         sec_pulse_q <= tick_apply;
      end
   end

   bcd_mod_counter #(
      .TensMax      (SEC_MAX / 10),
      .OnesMax      (SEC_MAX % 10),
      .DIGIT_W      (DIGIT_W),
      .BlankZeroTens(1'b0)
   ) u_sec (
      .clk        (clk),
      .rst        (rst),
      .inc        (tick_apply),
      .set_inc    (1'b0),
      .carry_in_en(1'b1),
      .ones       (bus.D0),
      .tens       (bus.D1),
      .carry_out  (sec_carry)
   );

   bcd_mod_counter #(
      .TensMax      (MIN_MAX / 10),
      .OnesMax      (MIN_MAX % 10),
      .DIGIT_W      (DIGIT_W),
      .BlankZeroTens(1'b0)
   ) u_min (
      .clk        (clk),
      .rst        (rst),
      .inc        (tick_apply),
      .set_inc    (bus.inc_min),
      .carry_in_en(sec_carry),
      .ones       (bus.D2),
      .tens       (bus.D3),
      .carry_out  (min_carry)
   );

   bcd_mod_counter #(
      .TensMax      (HOUR_MAX / 10),
      .OnesMax      (HOUR_MAX % 10),
      .DIGIT_W      (DIGIT_W),
      .BlankZeroTens(BlankLead)
   ) u_hour (
      .clk        (clk),
      .rst        (rst),
      .inc        (tick_apply),
      .set_inc    (bus.inc_hour),
      .carry_in_en(min_carry),
      .ones       (bus.D4),
      .tens       (bus.D5),
      .carry_out  (unused_hour_carry)
   );

   assign bus.sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: directed table, corner sequences and random run vs a seconds-of-day model.
module tb_hms_time_counter;
   import hms_pkg::*;

   localparam int unsigned TICK_DIV = 4;
   localparam int DIGW6 = 6 * DIGIT_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hms_time_counter_if #(.DIGIT_W(DIGIT_W)) bus ();

   hms_time_counter #(
      .TICK_DIV(TICK_DIV),
      .DIGIT_W (DIGIT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: time as seconds since midnight plus a prescaler count.
   int m_t     = 0;
   int m_presc = 0;
   bit m_pulse = 1'b0;

   typedef struct {
      bit r, e, im, ih;
      int hh, mm, ss;
      bit p;
   } vec_t;

   function automatic logic [DIGW6-1:0] exp_digits(input int t);
      int hh, mm, ss;
      digit_t w5;
      hh = t / 3600;
      mm = (t / 60) % 60;
      ss = t % 60;
      w5 = DIGIT_W'(hh / 10);
`ifdef HMS_LEADING_BLANK_EN
      if (hh / 10 == 0) w5 = BLANK_CODE;
`endif
      return {w5, DIGIT_W'(hh % 10), DIGIT_W'(mm / 10), DIGIT_W'(mm % 10),
              DIGIT_W'(ss / 10), DIGIT_W'(ss % 10)};
   endfunction

   function automatic logic [DIGW6-1:0] dut_digits();
      return {bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      n_total++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
   endtask

   task automatic model_step(input bit r, input bit e, input bit im, input bit ih);
      bit tk;
      int hh, mm, ss;
      if (r) begin
         m_t = 0; m_presc = 0; m_pulse = 1'b0;
      end else begin
         tk = e && (m_presc == TICK_DIV - 1);
         if (e) m_presc = tk ? 0 : m_presc + 1;
         m_pulse = 1'b0;
         if (im || ih) begin
            hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
            if (im) mm = (mm + 1) % 60;
            if (ih) hh = (hh + 1) % 24;
            m_t = hh * 3600 + mm * 60 + ss;
         end else if (tk) begin
            m_t = (m_t + 1) % 86400;
            m_pulse = 1'b1;
         end
      end
   endtask

   // One clock: drive on negedge, advance model at posedge, compare 1 time unit later.
   task automatic step(input bit r, input bit e, input bit im, input bit ih);
      @(negedge clk);
      rst = r; bus.en = e; bus.inc_min = im; bus.inc_hour = ih;
      @(posedge clk);
      model_step(r, e, im, ih);
      #1;
      check("model_digits", 64'(dut_digits()), 64'(exp_digits(m_t)));
      check("model_pulse", 64'(bus.sec_pulse), 64'(m_pulse));
   endtask

   task automatic run(input int n, input bit e);
      for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0);
   endtask

   task automatic presses(input int n, input bit im, input bit ih);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, im, ih);
   endtask

   // Cycles until the next sec_pulse with en=1, -1 if none within the bound.
   task automatic cycles_to_pulse(output int n);
      n = -1;
      for (int i = 1; i <= 4 * TICK_DIV; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         if (bus.sec_pulse === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   function automatic int hms(input int hh, input int mm, input int ss);
      return hh * 3600 + mm * 60 + ss;
   endfunction

   vec_t vecs[17];
   int   n;
   int   pulses;

   initial begin
      bus.en = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;

      vecs[0]  = '{1, 0, 0, 0,  0, 0, 0, 0};
      vecs[1]  = '{0, 1, 0, 0,  0, 0, 0, 0};
      vecs[2]  = '{0, 1, 0, 0,  0, 0, 0, 0};
      vecs[3]  = '{0, 1, 0, 0,  0, 0, 0, 0};
      vecs[4]  = '{0, 1, 0, 0,  0, 0, 1, 1};
      vecs[5]  = '{0, 0, 1, 0,  0, 1, 1, 0};
      vecs[6]  = '{0, 0, 0, 1,  1, 1, 1, 0};
      vecs[7]  = '{0, 0, 1, 1,  2, 2, 1, 0};
      vecs[8]  = '{0, 1, 0, 0,  2, 2, 1, 0};
      vecs[9]  = '{0, 1, 0, 0,  2, 2, 1, 0};
      vecs[10] = '{0, 1, 0, 0,  2, 2, 1, 0};
      vecs[11] = '{0, 1, 1, 0,  2, 3, 1, 0};
      vecs[12] = '{0, 1, 0, 0,  2, 3, 1, 0};
      vecs[13] = '{0, 1, 0, 0,  2, 3, 1, 0};
      vecs[14] = '{0, 1, 0, 0,  2, 3, 1, 0};
      vecs[15] = '{0, 1, 0, 0,  2, 3, 2, 1};
      vecs[16] = '{1, 1, 1, 1,  0, 0, 0, 0};

      for (int i = 0; i < 17; i++) begin
         step(vecs[i].r, vecs[i].e, vecs[i].im, vecs[i].ih);
         check($sformatf("vec%0d_digits", i), 64'(dut_digits()),
               64'(exp_digits(hms(vecs[i].hh, vecs[i].mm, vecs[i].ss))));
         check($sformatf("vec%0d_pulse", i), 64'(bus.sec_pulse), 64'(vecs[i].p));
      end

      // 60 ticks from reset reach 00:01:00.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run(60 * TICK_DIV, 1'b1);
      check("sixty_ticks", 64'(dut_digits()), 64'(exp_digits(hms(0, 1, 0))));

      // Preload 23:59:00, run into midnight.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      presses(23, 1'b0, 1'b1);
      presses(59, 1'b1, 1'b0);
      check("preload", 64'(dut_digits()), 64'(exp_digits(hms(23, 59, 0))));
      run(60 * TICK_DIV - 1, 1'b1);
      check("pre_wrap", 64'(dut_digits()), 64'(exp_digits(hms(23, 59, 59))));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("wrap_digits", 64'(dut_digits()), 64'(exp_digits(0)));
      check("wrap_pulse", 64'(bus.sec_pulse), 64'd1);

      // Pause mid-count: prescaler at 2 is held for 20 cycles.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run(2 * TICK_DIV - 2, 1'b1);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.sec_pulse === 1'b1) pulses++;
      end
      check("pause_pulses", 64'(pulses), 64'd0);
      check("pause_digits", 64'(dut_digits()), 64'(exp_digits(hms(0, 0, 1))));
      cycles_to_pulse(n);
      check("resume_latency", 64'(n), 64'd2);

      // inc_min exactly on the tick at 00:00:05.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run(5 * TICK_DIV + TICK_DIV - 1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("set_on_tick_digits", 64'(dut_digits()), 64'(exp_digits(hms(0, 1, 5))));
      check("set_on_tick_pulse", 64'(bus.sec_pulse), 64'd0);
      cycles_to_pulse(n);
      check("after_set_latency", 64'(n), 64'(TICK_DIV));

      // Manual wraps: 23 -> 00 hours, xx:59 -> xx:00 with hours kept.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      presses(23, 1'b0, 1'b1);
      presses(1, 1'b0, 1'b1);
      check("hour_wrap", 64'(dut_digits()), 64'(exp_digits(0)));
      presses(5, 1'b0, 1'b1);
      presses(60, 1'b1, 1'b0);
      check("min_wrap", 64'(dut_digits()), 64'(exp_digits(hms(5, 0, 0))));

      // Reset from 12:34:56 mid-count, then leading-digit behaviour.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      presses(12, 1'b0, 1'b1);
      presses(34, 1'b1, 1'b0);
      run(56 * TICK_DIV + 2, 1'b1);
      check("at_123456", 64'(dut_digits()), 64'(exp_digits(hms(12, 34, 56))));
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_pulse", 64'(bus.sec_pulse), 64'd0);
`ifdef HMS_LEADING_BLANK_EN
      check("rst_d5", 64'(bus.D5), 64'(BLANK_CODE));
`else
      check("rst_d5", 64'(bus.D5), 64'd0);
`endif
      check("rst_d0", 64'(bus.D0), 64'd0);
      cycles_to_pulse(n);
      check("rst_presc", 64'(n), 64'(TICK_DIV));
      presses(9, 1'b0, 1'b1);
      presses(1, 1'b0, 1'b1);
      check("hour10_d5", 64'(bus.D5), 64'd1);
      check("hour10_d4", 64'(bus.D4), 64'd0);

      // Random traffic against the model.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(199) == 0), ($urandom_range(3) != 0),
              ($urandom_range(15) == 0), ($urandom_range(15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
